// File: rtl/rx_bit_timer_p.sv
`default_nettype none
// ============================================================================
//  Module      : rx_bit_timer_p
//  Description : Parametrised USB RX bit timer. Produces one shift_enable
//                pulse per bit at a programmable sample point, flags byte
//                completion, and re-aligns the bit phase on incoming edges
//                while reporting edges that land too close to the sample.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module rx_bit_timer_p #(
  parameter int CLKS_PER_BIT  = 8,
  parameter int SAMPLE_POINT  = 3,
  parameter int BITS_PER_BYTE = 8,
  parameter int RESYNC_EN     = 1,
  localparam int CNT_W        = $clog2(CLKS_PER_BIT),
  localparam int BIT_W        = $clog2(BITS_PER_BYTE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rcving,
  input  logic             d_edge,
  output logic             shift_enable,
  output logic             byte_received,
  output logic [BIT_W-1:0] bit_idx,
  output logic             align_err
);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_POINT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(BITS_PER_BYTE - 1);
  localparam bit               RESYNC_ON  = (RESYNC_EN != 0);

  logic             active;
  logic [CNT_W-1:0] clk_cnt;
  logic [BIT_W-1:0] bit_cnt;

  logic [CNT_W-1:0] cnt_wrap;
  logic [CNT_W-1:0] cnt_next;
  logic [BIT_W-1:0] bit_next;
  logic             edge_seen;
  logic             edge_early;
  logic             edge_late;

  // Outputs are pure decodes of registered state, so they never glitch on inputs.
  assign shift_enable = active && (clk_cnt == CNT_SAMPLE);
  assign bit_idx      = bit_cnt;

  // Phase/bit-count next-state: classify an edge against the sample point.
  // An edge at clk_cnt 0 or after the sample point starts a new bit (the edge
  // cycle is bit clock 0, so the counter jumps to 1). An edge between 1 and
  // the sample point, inclusive, would cause a double or skipped sample, so it
  // is rejected and the phase simply keeps running.
  always_comb begin
    cnt_wrap   = (clk_cnt == CNT_LAST) ? '0 : clk_cnt + CNT_ONE;
    edge_seen  = RESYNC_ON && active && d_edge;
    edge_early = edge_seen && (clk_cnt != '0) && (clk_cnt <= CNT_SAMPLE);
    edge_late  = edge_seen && !edge_early;
    cnt_next   = edge_late ? CNT_ONE : cnt_wrap;
    bit_next   = bit_cnt;
    if (shift_enable) begin
      bit_next = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
    end
  end

  // Receive window register: active follows rcving one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
    end else begin
      active <= rcving;
    end
  end

  // Bit-phase and bit-index counters; dropping rcving discards all progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else if (!rcving) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else if (active) begin
      clk_cnt <= cnt_next;
      bit_cnt <= bit_next;
    end
  end

  // Status pulses; byte_received still fires if rcving drops on the last shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_received <= 1'b0;
      align_err     <= 1'b0;
    end else begin
      byte_received <= shift_enable && (bit_cnt == BIT_LAST);
      align_err     <= edge_early;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_bit_timer_p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_bit_timer_p
//  Description : Self-checking bench for rx_bit_timer_p (default instance
//                plus a small non-resync instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_bit_timer_p;

  typedef struct {
    logic       rcv;
    logic       de;
    logic       se;
    logic       br;
    logic [2:0] idx;
    logic       ae;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rcving, d_edge;
  logic       shift_enable, byte_received, align_err;
  logic [2:0] bit_idx;

  logic       rcving_b, d_edge_b;
  logic       shift_enable_b, byte_received_b, align_err_b;
  logic [1:0] bit_idx_b;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[$];
  int   m_idx;
  bit   m_br;

  always #5 clk = ~clk;

  rx_bit_timer_p dut (
    .clk(clk), .rst(rst), .rcving(rcving), .d_edge(d_edge),
    .shift_enable(shift_enable), .byte_received(byte_received),
    .bit_idx(bit_idx), .align_err(align_err)
  );

  rx_bit_timer_p #(
    .CLKS_PER_BIT(4), .SAMPLE_POINT(1), .BITS_PER_BYTE(4), .RESYNC_EN(0)
  ) dut_b (
    .clk(clk), .rst(rst), .rcving(rcving_b), .d_edge(d_edge_b),
    .shift_enable(shift_enable_b), .byte_received(byte_received_b),
    .bit_idx(bit_idx_b), .align_err(align_err_b)
  );

  task automatic chk(input string name, input int n,
                     input logic se, input logic br, input logic [2:0] idx, input logic ae,
                     input logic w_se, input logic w_br, input logic [2:0] w_idx, input logic w_ae);
    checks++;
    if ({se, br, idx, ae} !== {w_se, w_br, w_idx, w_ae}) begin
      failures++;
      $display("FAIL %s[%0d] got se=%b br=%b idx=%0d ae=%b want se=%b br=%b idx=%0d ae=%b",
               name, n, se, br, idx, ae, w_se, w_br, w_idx, w_ae);
    end
  endtask

  task automatic model_reset();
    m_idx = 0;
    m_br  = 1'b0;
    vecs.delete();
  endtask

  // Append one cycle: expected bit index and byte flag follow from the expected pulses.
  task automatic add(input bit rcv, input bit de, input bit se, input bit ae);
    vec_t v;
    v.rcv = rcv; v.de = de; v.se = se; v.ae = ae;
    v.idx = 3'(m_idx);
    v.br  = m_br;
    vecs.push_back(v);
    m_br = se && (m_idx == 7);
    if (se) m_idx = (m_idx + 1) % 8;
    if (!rcv) m_idx = 0;
  endtask

  task automatic run_vecs(input string name);
    foreach (vecs[i]) begin
      @(negedge clk);
      rcving = vecs[i].rcv;
      d_edge = vecs[i].de;
      #1;
      chk(name, i, shift_enable, byte_received, bit_idx, align_err,
          vecs[i].se, vecs[i].br, vecs[i].idx, vecs[i].ae);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    rcving = 1'b0;
    d_edge = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rcving = 1'b0; d_edge = 1'b0; rcving_b = 1'b0; d_edge_b = 1'b0;
    #1;
    chk("reset", 0, shift_enable, byte_received, bit_idx, align_err, 0, 0, 3'd0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Free run: pulses at 3,11,...,59; byte_received at 60 only.
    model_reset();
    add(1, 0, 0, 0);
    for (int k = 0; k <= 63; k++) add(1, 0, (k % 8) == 3, 0);
    run_vecs("freerun");
    go_idle();

    // Late edge at clk_cnt=6: next pulse 3 cycles after the edge, no align_err.
    model_reset();
    add(1, 0, 0, 0);
    for (int k = 0; k <= 18; k++) add(1, k == 6, (k == 3) || (k == 9) || (k == 17), 0);
    run_vecs("late");
    go_idle();

    // Early edges at clk_cnt=2 and 3 (the latter a pulse cycle); also an edge while inactive.
    model_reset();
    add(1, 1, 0, 0);
    for (int k = 0; k <= 20; k++) add(1, (k == 2) || (k == 11), (k % 8) == 3, (k == 3) || (k == 12));
    run_vecs("early");
    go_idle();

    // rcving drops on the 8th pulse, reasserted the next cycle.
    model_reset();
    add(1, 0, 0, 0);
    for (int k = 0; k <= 66; k++) add(k != 59, 0, ((k <= 59) && ((k % 8) == 3)) || (k == 64), 0);
    run_vecs("drop");
    go_idle();

    // Reset mid-byte on the bit-5 pulse: outputs clear without waiting for a clock.
    model_reset();
    add(1, 0, 0, 0);
    for (int k = 0; k <= 43; k++) add(1, 0, (k % 8) == 3, 0);
    run_vecs("prerst");
    #1;
    rst = 1'b1;
    rcving = 1'b0;
    #1;
    chk("async_rst", 0, shift_enable, byte_received, bit_idx, align_err, 0, 0, 3'd0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("post_rst", k, shift_enable, byte_received, bit_idx, align_err, 0, 0, 3'd0, 0);
    end

    // Small free-running instance: pulses 1,5,9,13; byte at 14; edges have no effect.
    @(negedge clk);
    rcving_b = 1'b1;
    #1;
    chk("small", -1, shift_enable_b, byte_received_b, {1'b0, bit_idx_b}, align_err_b, 0, 0, 3'd0, 0);
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      d_edge_b = (k == 0) || (k == 2) || (k == 5) || (k == 7);
      #1;
      chk("small", k, shift_enable_b, byte_received_b, {1'b0, bit_idx_b}, align_err_b,
          (k % 4) == 1, k == 14, (k <= 1) ? 3'd0 : 3'((((k - 2) / 4) + 1) % 4), 1'b0);
    end
    d_edge_b = 1'b0;
    rcving_b = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
